// File: rtl/tri_1r1w_bw_array_pkg.sv
// Shared types and elaboration helpers for the parametrised 1R1W bit-write array.
package tri_array_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  function automatic bit rd_lat_legal(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/tri_1r1w_bw_array_if.sv
// Clear/write/read bus of the 1R1W bit-write array; the user side is the master.
interface tri_1r1w_bw_array_if #(
  parameter int ADDR_W = 9,
  parameter int WIDTH  = 16
);
  logic              clr_req;
  logic              init_busy;
  logic              wr_act;
  logic [0:ADDR_W-1] wr_adr;
  logic [0:WIDTH-1]  bw;
  logic [0:WIDTH-1]  di;
  logic              rd_act;
  logic [0:ADDR_W-1] rd_adr;
  logic [0:WIDTH-1]  dout;
  logic              rd_val;

  modport master (
    output clr_req, wr_act, wr_adr, bw, di, rd_act, rd_adr,
    input  init_busy, dout, rd_val
  );

  modport slave (
    input  clr_req, wr_act, wr_adr, bw, di, rd_act, rd_adr,
    output init_busy, dout, rd_val
  );
endinterface

// File: rtl/tri_1r1w_bw_array_core.sv
// Behavioural storage: one bit-masked write port, one asynchronous read port.
module tri_1r1w_bw_array_core #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9,
  parameter int WIDTH  = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [0:ADDR_W-1] wa,
  input  logic [0:WIDTH-1]  wmask,
  input  logic [0:WIDTH-1]  wdata,
  input  logic [0:ADDR_W-1] ra,
  output logic [0:WIDTH-1]  rdata
);

  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  logic [0:WIDTH-1] mem [0:DEPTH-1];
  logic             wa_ok;
  logic             ra_ok;

  assign wa_ok = {1'b0, wa} < DEPTH_X;
  assign ra_ok = {1'b0, ra} < DEPTH_X;

  always_ff @(posedge clk) begin
    if (we && wa_ok) begin
      mem[wa] <= (mem[wa] & ~wmask) | (wdata & wmask);
    end
  end

  // Unpopulated addresses read as zero rather than aliasing.
  assign rdata = ra_ok ? mem[ra] : '0;

endmodule

// File: rtl/tri_1r1w_bw_array.sv
// Parametrised 1R1W bit-write array with hardware clear, same-cycle bypass and read-valid strobe.
//   state   | meaning
//   ST_INIT | zeroing entry clr_cnt each cycle; user traffic ignored
//   ST_RUN  | normal reads and bit-masked writes
module tri_1r1w_bw_array
  import tri_array_pkg::*;
#(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9,
  parameter int WIDTH  = 16,
  parameter int RD_LAT = 1,
  parameter int BYPASS = 1
) (
  input  logic                clk,
  input  logic                reset_b,
  tri_1r1w_bw_array_if.slave  bus
);

  if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
    $error("RD_LAT must be 1 or 2");
  end
  if ((DEPTH < 2) || (clog2(DEPTH) > ADDR_W)) begin : g_bad_depth
    $error("DEPTH must be >= 2 and fit in ADDR_W bits");
  end

  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(DEPTH - 1);

  state_e            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              init_busy_q;
  logic              s1_val;
  logic [0:WIDTH-1]  s1_data;
  logic              rd_val_q;
  logic [0:WIDTH-1]  dout_q;

  logic              run_ok;
  logic              wr_ok;
  logic              rd_ok;
  logic              core_we;
  logic [0:ADDR_W-1] core_wa;
  logic [0:WIDTH-1]  core_wmask;
  logic [0:WIDTH-1]  core_wdata;
  logic [0:WIDTH-1]  core_rdata;
  logic [0:WIDTH-1]  merged;
  logic [0:WIDTH-1]  rd_sel;

  // A clear request pre-empts any user access in the same cycle.
  always_comb begin
    run_ok     = (state == ST_RUN) && !bus.clr_req;
    wr_ok      = run_ok && bus.wr_act && ({1'b0, bus.wr_adr} < DEPTH_X) && (|bus.bw);
    rd_ok      = run_ok && bus.rd_act;
    core_we    = (state == ST_INIT) || wr_ok;
    core_wa    = (state == ST_INIT) ? clr_cnt : bus.wr_adr;
    core_wmask = (state == ST_INIT) ? '1 : bus.bw;
    core_wdata = (state == ST_INIT) ? '0 : bus.di;
    merged     = (core_rdata & ~bus.bw) | (bus.di & bus.bw);
    rd_sel     = core_rdata;
    if ((BYPASS != 0) && wr_ok && (bus.wr_adr == bus.rd_adr)) begin
      rd_sel = merged;
    end
  end

  tri_1r1w_bw_array_core #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (WIDTH)
  ) u_core (
    .clk   (clk),
    .we    (core_we),
    .wa    (core_wa),
    .wmask (core_wmask),
    .wdata (core_wdata),
    .ra    (bus.rd_adr),
    .rdata (core_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state       <= ST_INIT;
      clr_cnt     <= '0;
      init_busy_q <= 1'b1;
      s1_val      <= 1'b0;
      s1_data     <= '0;
      rd_val_q    <= 1'b0;
      dout_q      <= '0;
    end else begin
      if (state == ST_INIT) begin
        if (bus.clr_req) begin
          clr_cnt <= '0;
        end else if (clr_cnt == LAST_CNT) begin
          state       <= ST_RUN;
          clr_cnt     <= '0;
          init_busy_q <= 1'b0;
        end else begin
          clr_cnt <= clr_cnt + ADDR_W'(1);
        end
      end else if (bus.clr_req) begin
        state       <= ST_INIT;
        clr_cnt     <= '0;
        init_busy_q <= 1'b1;
      end

      s1_val <= rd_ok;
      if (rd_ok) s1_data <= rd_sel;

      // The second stage is killed when a clear starts, so no strobe leaks into INIT.
      if (RD_LAT == 1) begin
        rd_val_q <= rd_ok;
        if (rd_ok) dout_q <= rd_sel;
      end else begin
        rd_val_q <= s1_val && run_ok;
        if (s1_val && run_ok) dout_q <= s1_data;
      end
    end
  end

  assign bus.init_busy = init_busy_q;
  assign bus.rd_val    = rd_val_q;
  assign bus.dout      = dout_q;

endmodule

// File: tb/tb_tri_1r1w_bw_array.sv
// Bench: two instances (RD_LAT=1/BYPASS=1 and RD_LAT=2/BYPASS=0) driven by identical stimulus.
module tb_tri_1r1w_bw_array;

  logic clk;
  logic reset_b;
  int   n_chk;
  int   n_err;

  tri_1r1w_bw_array_if #(.ADDR_W(9), .WIDTH(16)) ifa ();
  tri_1r1w_bw_array_if #(.ADDR_W(9), .WIDTH(16)) ifb ();

  assign ifb.clr_req = ifa.clr_req;
  assign ifb.wr_act  = ifa.wr_act;
  assign ifb.wr_adr  = ifa.wr_adr;
  assign ifb.bw      = ifa.bw;
  assign ifb.di      = ifa.di;
  assign ifb.rd_act  = ifa.rd_act;
  assign ifb.rd_adr  = ifa.rd_adr;

  tri_1r1w_bw_array #(
    .DEPTH(512), .ADDR_W(9), .WIDTH(16), .RD_LAT(1), .BYPASS(1)
  ) dut_a (
    .clk     (clk),
    .reset_b (reset_b),
    .bus     (ifa.slave)
  );

  tri_1r1w_bw_array #(
    .DEPTH(512), .ADDR_W(9), .WIDTH(16), .RD_LAT(2), .BYPASS(0)
  ) dut_b (
    .clk     (clk),
    .reset_b (reset_b),
    .bus     (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit wr; int wa; int bw; int di;
    bit rd; int ra;
    bit av; int ad;
    bit bv; int bd;
  } vec_t;

  vec_t tbl [23];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ifa.clr_req = 1'b0;
    ifa.wr_act  = 1'b0;
    ifa.wr_adr  = '0;
    ifa.bw      = '0;
    ifa.di      = '0;
    ifa.rd_act  = 1'b0;
    ifa.rd_adr  = '0;
  endtask

  // Called #1 after the edge that starts INIT; counts post-edge samples with init_busy high.
  task automatic count_busy(input int ev_at, input bit ev_rst, input int exp_n, input string nm);
    int n;
    n = 0;
    while (ifa.init_busy && n < 3000) begin
      n++;
      chk({nm, "_rdval_a"}, 32'(ifa.rd_val), 0);
      chk({nm, "_rdval_b"}, 32'(ifb.rd_val), 0);
      reset_b     = 1'b1;
      ifa.clr_req = 1'b0;
      if (n == ev_at) begin
        if (ev_rst) reset_b = 1'b0;
        else        ifa.clr_req = 1'b1;
      end
      @(posedge clk); #1;
    end
    chk({nm, "_len"}, n, exp_n);
    chk({nm, "_busy_b"}, 32'(ifb.init_busy), 0);
    idle_inputs();
  endtask

  task automatic rd_chk(input int adr, input int exp, input string nm);
    @(negedge clk);
    ifa.rd_act = 1'b1;
    ifa.rd_adr = 9'(adr);
    @(negedge clk);
    ifa.rd_act = 1'b0;
    chk({nm, "_val_a"}, 32'(ifa.rd_val), 1);
    chk({nm, "_do_a"}, 32'(ifa.dout), exp);
    chk({nm, "_early_b"}, 32'(ifb.rd_val), 0);
    @(negedge clk);
    chk({nm, "_val_b"}, 32'(ifb.rd_val), 1);
    chk({nm, "_do_b"}, 32'(ifb.dout), exp);
    chk({nm, "_once_a"}, 32'(ifa.rd_val), 0);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset_b = 1'b0;
    idle_inputs();

    //          wr    wa   bw       di       rd    ra   av    ad       bv    bd
    tbl[0]  = '{1'b1, 5,   'hFFFF, 'hFFFF, 1'b0, 0,   1'b0, 'h0000, 1'b0, 'h0000};
    tbl[1]  = '{1'b1, 5,   'h00F0, 'h0000, 1'b0, 0,   1'b0, 'h0000, 1'b0, 'h0000};
    tbl[2]  = '{1'b0, 0,   'h0000, 'h0000, 1'b1, 5,   1'b1, 'hFF0F, 1'b0, 'h0000};
    tbl[3]  = '{1'b1, 9,   'hFFFF, 'h1234, 1'b0, 0,   1'b0, 'hFF0F, 1'b1, 'hFF0F};
    tbl[4]  = '{1'b1, 9,   'hFF00, 'hABCD, 1'b1, 9,   1'b1, 'hAB34, 1'b0, 'hFF0F};
    tbl[5]  = '{1'b0, 0,   'h0000, 'h0000, 1'b1, 9,   1'b1, 'hAB34, 1'b1, 'h1234};
    tbl[6]  = '{1'b1, 1,   'hFFFF, 'h0001, 1'b0, 0,   1'b0, 'hAB34, 1'b1, 'hAB34};
    tbl[7]  = '{1'b1, 2,   'hFFFF, 'h0002, 1'b0, 0,   1'b0, 'hAB34, 1'b0, 'hAB34};
    tbl[8]  = '{1'b1, 3,   'hFFFF, 'h0003, 1'b0, 0,   1'b0, 'hAB34, 1'b0, 'hAB34};
    tbl[9]  = '{1'b0, 0,   'h0000, 'h0000, 1'b1, 1,   1'b1, 'h0001, 1'b0, 'hAB34};
    tbl[10] = '{1'b0, 0,   'h0000, 'h0000, 1'b1, 2,   1'b1, 'h0002, 1'b1, 'h0001};
    tbl[11] = '{1'b0, 0,   'h0000, 'h0000, 1'b1, 3,   1'b1, 'h0003, 1'b1, 'h0002};
    tbl[12] = '{1'b0, 0,   'h0000, 'h0000, 1'b0, 0,   1'b0, 'h0003, 1'b1, 'h0003};
    tbl[13] = '{1'b0, 0,   'h0000, 'h0000, 1'b0, 0,   1'b0, 'h0003, 1'b0, 'h0003};
    tbl[14] = '{1'b1, 5,   'h0000, 'h0000, 1'b0, 0,   1'b0, 'h0003, 1'b0, 'h0003};
    tbl[15] = '{1'b0, 0,   'h0000, 'h0000, 1'b1, 5,   1'b1, 'hFF0F, 1'b0, 'h0003};
    tbl[16] = '{1'b0, 0,   'h0000, 'h0000, 1'b1, 0,   1'b1, 'h0000, 1'b1, 'hFF0F};
    tbl[17] = '{1'b0, 0,   'h0000, 'h0000, 1'b1, 255, 1'b1, 'h0000, 1'b1, 'h0000};
    tbl[18] = '{1'b0, 0,   'h0000, 'h0000, 1'b1, 511, 1'b1, 'h0000, 1'b1, 'h0000};
    tbl[19] = '{1'b0, 0,   'h0000, 'h0000, 1'b0, 0,   1'b0, 'h0000, 1'b1, 'h0000};
    tbl[20] = '{1'b1, 7,   'hFFFF, 'h5555, 1'b0, 0,   1'b0, 'h0000, 1'b0, 'h0000};
    tbl[21] = '{1'b0, 0,   'h0000, 'h0000, 1'b1, 7,   1'b1, 'h5555, 1'b0, 'h0000};
    tbl[22] = '{1'b0, 0,   'h0000, 'h0000, 1'b0, 0,   1'b0, 'h5555, 1'b1, 'h5555};

    // Reset values, then the power-on clear.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy_a", 32'(ifa.init_busy), 1);
    chk("rst_busy_b", 32'(ifb.init_busy), 1);
    chk("rst_rdval_a", 32'(ifa.rd_val), 0);
    chk("rst_rdval_b", 32'(ifb.rd_val), 0);
    chk("rst_do_a", 32'(ifa.dout), 0);
    chk("rst_do_b", 32'(ifb.dout), 0);
    count_busy(0, 1'b0, 512, "init_por");

    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      ifa.wr_act = tbl[i].wr;
      ifa.wr_adr = tbl[i].wa[8:0];
      ifa.bw     = tbl[i].bw[15:0];
      ifa.di     = tbl[i].di[15:0];
      ifa.rd_act = tbl[i].rd;
      ifa.rd_adr = tbl[i].ra[8:0];
      @(posedge clk); #1;
      chk($sformatf("vec%0d_val_a", i), 32'(ifa.rd_val), 32'(tbl[i].av));
      chk($sformatf("vec%0d_do_a", i),  32'(ifa.dout),   tbl[i].ad);
      chk($sformatf("vec%0d_val_b", i), 32'(ifb.rd_val), 32'(tbl[i].bv));
      chk($sformatf("vec%0d_do_b", i),  32'(ifb.dout),   tbl[i].bd);
    end
    @(negedge clk);
    idle_inputs();

    // Clear request with a colliding write, then user traffic held on during INIT.
    @(negedge clk);
    ifa.clr_req = 1'b1;
    ifa.wr_act  = 1'b1;
    ifa.wr_adr  = 9'd7;
    ifa.bw      = 16'hFFFF;
    ifa.di      = 16'hFFFF;
    ifa.rd_act  = 1'b1;
    ifa.rd_adr  = 9'd7;
    @(posedge clk); #1;
    count_busy(0, 1'b0, 512, "init_clr");
    rd_chk(7, 16'h0000, "clr_adr7");
    rd_chk(5, 16'h0000, "clr_adr5");

    // clr_req mid-INIT restarts the counter.
    @(negedge clk);
    ifa.clr_req = 1'b1;
    @(posedge clk); #1;
    count_busy(100, 1'b0, 612, "init_restart");

    // Reset with a two-cycle read in flight.
    @(negedge clk);
    ifa.wr_act = 1'b1;
    ifa.wr_adr = 9'd5;
    ifa.bw     = 16'hFFFF;
    ifa.di     = 16'h00FF;
    @(negedge clk);
    ifa.wr_act = 1'b0;
    ifa.rd_act = 1'b1;
    ifa.rd_adr = 9'd5;
    @(negedge clk);
    ifa.rd_act = 1'b0;
    chk("inflight_do_a", 32'(ifa.dout), 16'h00FF);
    reset_b = 1'b0;
    @(posedge clk); #1;
    chk("inflight_rdval_b", 32'(ifb.rd_val), 0);
    chk("inflight_do_b", 32'(ifb.dout), 0);
    chk("inflight_rdval_a", 32'(ifa.rd_val), 0);
    count_busy(0, 1'b1, 512, "init_rst_inflight");

    // Reset at INIT counter 100 restarts the full sequence.
    @(negedge clk);
    ifa.clr_req = 1'b1;
    @(posedge clk); #1;
    count_busy(100, 1'b1, 612, "init_rst_mid");
    rd_chk(5, 16'h0000, "final_adr5");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/tri_1r1w_bw_array.md
Name: tri_1r1w_bw_array

Overview:
- Parametrised successor to the fixed 512x16 one-read/one-write bit-write array wrapper.
- Depth, width and read latency are configurable, and bit-granular write enables are kept.
- Adds three features: same-cycle read/write bypass, a hardware clear sequencer (runs after reset and on request), and a read-valid strobe.
- Used by core-side tables (branch history, LRU, directory shadows) that need known-zero contents without a scan init.

Parameters:
- DEPTH, 512, number of addressable entries; must be at least 2.
- ADDR_W, 9, address width; 2^ADDR_W >= DEPTH.
- WIDTH, 16, data bits per entry.
- RD_LAT, 1, read latency in cycles; legal values 1 or 2 (2 adds an output register).
- BYPASS, 1, when 1, a same-cycle read and write to the same address returns the new data.

Ports:
- clk  in  1  array clock; all state updates on the rising edge.
- reset_b  in  1  synchronous, active-low reset.
- clr_req  in  1  single-cycle pulse; restarts the clear sequence.
- init_busy  out  1  high while the clear sequence runs.
- wr_act  in  1  write enable.
- wr_adr  in  [0:ADDR_W-1]  write address.
- bw  in  [0:WIDTH-1]  per-bit write enable.
- di  in  [0:WIDTH-1]  write data.
- rd_act  in  1  read enable.
- rd_adr  in  [0:ADDR_W-1]  read address.
- do  out  [0:WIDTH-1]  read data.
- rd_val  out  1  do carries the result of a read issued RD_LAT cycles earlier.

Behaviour:
- Reset (reset_b = 0 at a clock edge):
  - init_busy=1, rd_val=0, do=0, clear counter=0, state=INIT; all pipeline registers cleared.
  - Array contents are not reset directly; they are overwritten by INIT.
- FSM states:
  - INIT: each cycle writes all-zero to entry clr_cnt, then clr_cnt increments. When clr_cnt = DEPTH-1 has been written, go to RUN and set clr_cnt=0. Takes exactly DEPTH cycles.
  - RUN: normal operation. clr_req=1 moves to INIT on the next cycle.
- init_busy = (state == INIT). It deasserts on the edge that completes the write to entry DEPTH-1.
- During INIT:
  - wr_act and rd_act are ignored; no user write lands.
  - rd_val stays 0 and do holds its value.
- clr_req while already in INIT restarts the counter at 0.
- clr_req takes priority over a simultaneous user write in that cycle; the write is dropped.
- Write (RUN, wr_act=1):
  - For each bit i: new[i] = bw[i] ? di[i] : old[i].
  - The merge is a single-cycle read-modify-write in the behavioural model.
  - bw = all-zero means no write.
  - Addresses >= DEPTH are dropped.
- Read (RUN, rd_act=1):
  - RD_LAT=1: do and rd_val update on the next edge.
  - RD_LAT=2: do and rd_val update one edge later.
  - Addresses >= DEPTH return zero.
- do holds its last value when no valid read completes. rd_val is high for exactly one cycle per read.
- Collision (rd_act and wr_act on the same address, same cycle):
  - BYPASS=1: returns the merged new value.
  - BYPASS=0: returns the old value.
  - Write-then-read on the next cycle always sees the new data.
- Back-to-back reads at one per cycle are supported; the read pipeline never stalls.
- Reset mid-INIT or mid-read: the sequence restarts from zero and in-flight rd_val is killed.

Decomposition:
- Shared package tri_array_pkg holds:
  - the FSM state encoding (INIT=1'b0, RUN=1'b1);
  - the legal-RD_LAT check constant;
  - a clog2 function for ADDR_W sanity checks.
- Sub-module tri_1r1w_bw_array_core: the behavioural storage array, with one merged-write port and one asynchronous read port.
  - The top level holds the FSM, clear counter, bypass mux and output pipeline.

Test Plan:
- Reset, then hold reset_b=1 with DEPTH=512 -> init_busy=1 for exactly 512 cycles; after that, a read of addresses 0, 255 and 511 each returns 16'h0000 with rd_val.
- Write adr 5 with di=16'hFFFF, bw=16'hFFFF; then write adr 5 with di=16'h0000, bw=16'h00F0; then read adr 5 -> do=16'hFF0F, RD_LAT cycles after rd_act.
- Read and write adr 9 in the same cycle, old=16'h1234, di=16'hABCD, bw=16'hFF00 -> BYPASS=1: do=16'hAB34; BYPASS=0: do=16'h1234; the next read returns 16'hAB34.
- RD_LAT=2, reads to adr 1, 2, 3 on consecutive cycles after writing 16'h0001/0002/0003 -> rd_val high for 3 cycles starting 2 cycles later, with do=0001, 0002, 0003 in order.
- Write 16'h5555 to adr 7, pulse clr_req, assert wr_act during INIT -> init_busy high for DEPTH cycles; afterwards, adr 7 reads 16'h0000 and no INIT-window write has landed.
- Assert reset_b=0 at INIT counter 100 and with a read in flight -> rd_val never pulses; INIT restarts and lasts the full DEPTH cycles.
